// File: rtl/s247_core_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : s247_pkg
//  Description : Shared defaults, FSM state encoding and job descriptor type
//                for the s247 core scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package s247_pkg;

    localparam int DEF_NUM_CORES   = 8;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_WDOG_CYCLES = 1024;

    // Scheduler top-level state
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } sched_state_e;

    // Job descriptor at the default width
    typedef logic [DEF_DATA_WIDTH-1:0] job_desc_t;

    // Index width that stays legal for a single-entry range
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : s247_pkg
`default_nettype wire

// File: rtl/s247_core_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : s247_core_scheduler_if
//  Description : Job intake handshake and per-core start/done/busy bundle.
//                slave  = scheduler side, master = job source / core side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface s247_core_scheduler_if
    import s247_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  job_valid;
    logic                  job_ready;
    logic [DATA_WIDTH-1:0] job_data;
    logic [NUM_CORES-1:0]  core_start;
    logic [DATA_WIDTH-1:0] core_job;
    logic [NUM_CORES-1:0]  core_done;
    logic [NUM_CORES-1:0]  core_busy;

    modport slave (
        input  job_valid, job_data, core_done,
        output job_ready, core_start, core_job, core_busy
    );

    modport master (
        output job_valid, job_data, core_done,
        input  job_ready, core_start, core_job, core_busy
    );

endinterface : s247_core_scheduler_if
`default_nettype wire

// File: rtl/s247_core_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : s247_rr_arbiter
//  Description : Combinational round-robin picker. Searches upward from
//                last_grant+1 with wrap and returns the first requester as a
//                one-hot grant plus its index. No request -> grant of zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module s247_rr_arbiter
    import s247_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int IDX_W     = idx_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // Walk the candidates in priority order; the first requester wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            w_cand = IDX_W'((int'(last_grant) + off) % NUM_CORES);
            if (!w_found && req[w_cand]) begin
                w_found       = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule : s247_rr_arbiter
`default_nettype wire

// File: rtl/s247_core_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : s247_core_scheduler
//  Description : Job FIFO feeding a round-robin dispatcher over NUM_CORES
//                compute cores, with a RUN/HALT emergency state machine.
//                Optional per-core busy watchdog: define S247_SCHED_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module s247_core_scheduler
    import s247_pkg::*;
#(
    parameter int NUM_CORES   = DEF_NUM_CORES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,   // power of 2, >= 2
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES   // >= 2
) (
    input  logic                        wb_clk_i,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUM_CORES-1:0]        core_mask,
    input  logic                        emergency_halt,
    s247_core_scheduler_if.slave        sched,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [NUM_CORES-1:0]        timeout,
    output logic                        halted
);

    localparam int c_IDX_W = idx_width(NUM_CORES);
    localparam int c_PTR_W = idx_width(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0]         c_ST_RUN    = ST_RUN;
    localparam logic [0:0]         c_ST_HALT   = ST_HALT;
    localparam logic [c_IDX_W-1:0] c_LAST_RST  = c_IDX_W'(NUM_CORES - 1);
    localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);

    // Reset synchroniser: assertion is immediate, release follows two edges
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    logic [0:0]             r_state;
    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [NUM_CORES-1:0]   r_busy;
    logic [NUM_CORES-1:0]   r_core_start;
    logic [DATA_WIDTH-1:0]  r_core_job;
    logic [c_IDX_W-1:0]     r_last_grant;

    logic                   w_halted;
    logic                   w_job_ready;
    logic                   w_halt_enter;
    logic                   w_push;
    logic                   w_dispatch;
    logic [NUM_CORES-1:0]   w_req;
    logic [NUM_CORES-1:0]   w_grant;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic [NUM_CORES-1:0]   w_wdog_expire;

    // Two-flop reset release chain
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Handshake and dispatch qualification. Eligibility looks only at the
    // registered busy vector, so a core freed this cycle is granted next cycle.
    assign w_halted     = (r_state == c_ST_HALT);
    assign w_job_ready  = (r_count < c_FIFO_FULL) && !w_halted;
    assign w_halt_enter = (r_state == c_ST_RUN) && emergency_halt;
    assign w_push       = sched.job_valid && w_job_ready && !w_halt_enter;
    assign w_req        = core_mask & ~r_busy;
    assign w_dispatch   = (r_state == c_ST_RUN) && !emergency_halt && enable &&
                          (r_count != '0) && (|w_req);

    s247_rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (c_IDX_W)
    ) u_rr_arbiter (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    // RUN/HALT state: leave HALT only once the halt request is gone and
    // dispatch has been explicitly disabled
    always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN:  if (emergency_halt)            r_state <= c_ST_HALT;
                c_ST_HALT: if (!emergency_halt && !enable) r_state <= c_ST_RUN;
                default:                                  r_state <= c_ST_RUN;
            endcase
        end
    end

    // FIFO pointers and occupancy; HALT entry flushes everything
    always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_halt_enter) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_dispatch) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_dispatch})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sched.job_data;
        end
    end

    // Registered start pulse and descriptor; descriptor reads zero when idle
    always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_core_start <= '0;
            r_core_job   <= '0;
            r_last_grant <= c_LAST_RST;
        end else begin
            r_core_start <= w_dispatch ? w_grant : '0;
            r_core_job   <= w_dispatch ? r_mem[r_rd_ptr] : '0;
            if (w_dispatch) begin
                r_last_grant <= w_grant_idx;
            end
        end
    end

    // Busy ownership: set by a grant, cleared by done, watchdog or HALT
    always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_busy <= '0;
        end else if (w_halt_enter) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~sched.core_done & ~w_wdog_expire) |
                      (w_dispatch ? w_grant : '0);
        end
    end

`ifdef S247_SCHED_WDOG_EN
    localparam int c_WDOG_W = idx_width(WDOG_CYCLES);

    logic [NUM_CORES-1:0] r_timeout;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_wdog
        logic [c_WDOG_W-1:0] r_cnt;

        // Per-core busy-cycle counter, restarted at each grant to this core
        always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_cnt <= '0;
            end else if (w_halt_enter || (w_dispatch && w_grant[gi])) begin
                r_cnt <= '0;
            end else if (r_busy[gi]) begin
                r_cnt <= r_cnt + c_WDOG_W'(1);
            end
        end

        assign w_wdog_expire[gi] = r_busy[gi] &&
                                   (r_cnt == c_WDOG_W'(WDOG_CYCLES - 1));
    end

    // Timeout flags latch on expiry and hold until reset
    always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_timeout <= '0;
        end else begin
            r_timeout <= r_timeout | w_wdog_expire;
        end
    end

    assign timeout = r_timeout;
`else
    // Watchdog compiled out: no counters, flags read constant zero
    localparam logic c_WDOG_ACTIVE = 1'b0 && (WDOG_CYCLES > 0);

    assign w_wdog_expire = '0;
    assign timeout       = {NUM_CORES{c_WDOG_ACTIVE}};
`endif

    assign sched.job_ready  = w_job_ready;
    assign sched.core_start = r_core_start;
    assign sched.core_job   = r_core_job;
    assign sched.core_busy  = r_busy;
    assign fifo_count       = r_count;
    assign halted           = w_halted;

endmodule : s247_core_scheduler
`default_nettype wire

// File: tb/tb_s247_core_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s247_core_scheduler
//  Description : Directed self-checking bench for s247_core_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_s247_core_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] core_mask;
    logic       emergency_halt;
    logic [2:0] fifo_count;
    logic [7:0] timeout;
    logic       halted;

    int n_tests;
    int n_fail;

    s247_core_scheduler_if #(.NUM_CORES(8), .DATA_WIDTH(32)) sched ();

    s247_core_scheduler #(
        .NUM_CORES   (8),
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (4),
        .WDOG_CYCLES (16)
    ) dut (
        .wb_clk_i       (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .core_mask      (core_mask),
        .emergency_halt (emergency_halt),
        .sched          (sched),
        .fifo_count     (fifo_count),
        .timeout        (timeout),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        enable          = 1'b0;
        core_mask       = 8'h00;
        emergency_halt  = 1'b0;
        sched.job_valid = 1'b0;
        sched.job_data  = 32'h0;
        sched.core_done = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        step();
        n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL rst_start: got %h expected %h", sched.core_start, 8'h00); end
        n_tests++; if (sched.core_job !== 32'h0) begin n_fail++; $display("FAIL rst_job: got %h expected %h", sched.core_job, 32'h0); end
        n_tests++; if (sched.core_busy !== 8'h00) begin n_fail++; $display("FAIL rst_busy: got %h expected %h", sched.core_busy, 8'h00); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected %0d", fifo_count, 0); end
        n_tests++; if (timeout !== 8'h00) begin n_fail++; $display("FAIL rst_timeout: got %h expected %h", timeout, 8'h00); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected %b", halted, 1'b0); end
        step();
        rst_n = 1'b1;
        repeat (3) step();
        n_tests++; if (sched.job_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected %b", sched.job_ready, 1'b1); end
    endtask

    // Jobs A0..A7 stream onto cores 0..7 in order, one per cycle
    task automatic test_round_robin();
        logic [7:0]  exp_start;
        logic [31:0] exp_job;
        do_reset();
        enable    = 1'b1;
        core_mask = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                sched.job_valid = 1'b1;
                sched.job_data  = 32'hA0 + 32'(i);
            end else begin
                sched.job_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 8) begin
                exp_start = 8'h01 << (i - 1);
                exp_job   = 32'hA0 + 32'(i - 1);
            end else begin
                exp_start = 8'h00;
                exp_job   = 32'h0;
            end
            if (i >= 1) begin
                n_tests++; if (sched.core_start !== exp_start) begin n_fail++; $display("FAIL rr_start[%0d]: got %h expected %h", i, sched.core_start, exp_start); end
                n_tests++; if (sched.core_job !== exp_job) begin n_fail++; $display("FAIL rr_job[%0d]: got %h expected %h", i, sched.core_job, exp_job); end
            end
        end
        n_tests++; if (sched.core_busy !== 8'hFF) begin n_fail++; $display("FAIL rr_busy: got %h expected %h", sched.core_busy, 8'hFF); end
    endtask

    // Continues with every core busy: fill the FIFO, then free core 3
    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            sched.job_valid = 1'b1;
            sched.job_data  = 32'hB0 + 32'(i);
            step();
        end
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", fifo_count, 4); end
        n_tests++; if (sched.job_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected %b", sched.job_ready, 1'b0); end
        sched.job_data  = 32'hB4;
        sched.core_done = 8'h08;
        step();
        sched.core_done = 8'h00;
        n_tests++; if (sched.core_busy !== 8'hF7) begin n_fail++; $display("FAIL full_busy_done: got %h expected %h", sched.core_busy, 8'hF7); end
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count_hold: got %0d expected %0d", fifo_count, 4); end
        n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL full_no_start: got %h expected %h", sched.core_start, 8'h00); end
        step();
        n_tests++; if (sched.core_start !== 8'h08) begin n_fail++; $display("FAIL full_restart: got %h expected %h", sched.core_start, 8'h08); end
        n_tests++; if (sched.core_job !== 32'hB0) begin n_fail++; $display("FAIL full_restart_job: got %h expected %h", sched.core_job, 32'hB0); end
        n_tests++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL full_count_pop: got %0d expected %0d", fifo_count, 3); end
        n_tests++; if (sched.core_busy !== 8'hFF) begin n_fail++; $display("FAIL full_busy_again: got %h expected %h", sched.core_busy, 8'hFF); end
        step();
        sched.job_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_late_push: got %0d expected %0d", fifo_count, 4); end
        n_tests++; if (sched.core_job !== 32'h0) begin n_fail++; $display("FAIL full_job_idle: got %h expected %h", sched.core_job, 32'h0); end
    endtask

    // Only cores 0 and 2 eligible; third job waits for a completion
    task automatic test_mask();
        do_reset();
        core_mask = 8'h05;
        for (int i = 0; i < 3; i++) begin
            sched.job_valid = 1'b1;
            sched.job_data  = 32'hC0 + 32'(i);
            step();
        end
        sched.job_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mask_queued: got %0d expected %0d", fifo_count, 3); end
        n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL mask_disabled: got %h expected %h", sched.core_start, 8'h00); end
        enable = 1'b1;
        step();
        n_tests++; if (sched.core_start !== 8'h01) begin n_fail++; $display("FAIL mask_first: got %h expected %h", sched.core_start, 8'h01); end
        n_tests++; if (sched.core_job !== 32'hC0) begin n_fail++; $display("FAIL mask_first_job: got %h expected %h", sched.core_job, 32'hC0); end
        step();
        n_tests++; if (sched.core_start !== 8'h04) begin n_fail++; $display("FAIL mask_second: got %h expected %h", sched.core_start, 8'h04); end
        n_tests++; if (sched.core_job !== 32'hC1) begin n_fail++; $display("FAIL mask_second_job: got %h expected %h", sched.core_job, 32'hC1); end
        repeat (3) step();
        n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL mask_wait: got %h expected %h", sched.core_start, 8'h00); end
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL mask_wait_count: got %0d expected %0d", fifo_count, 1); end
        sched.core_done = 8'h20;
        step();
        sched.core_done = 8'h00;
        n_tests++; if (sched.core_busy !== 8'h05) begin n_fail++; $display("FAIL mask_idle_done: got %h expected %h", sched.core_busy, 8'h05); end
        sched.core_done = 8'h01;
        step();
        sched.core_done = 8'h00;
        n_tests++; if (sched.core_busy !== 8'h04) begin n_fail++; $display("FAIL mask_done0: got %h expected %h", sched.core_busy, 8'h04); end
        step();
        n_tests++; if (sched.core_start !== 8'h01) begin n_fail++; $display("FAIL mask_third: got %h expected %h", sched.core_start, 8'h01); end
        n_tests++; if (sched.core_job !== 32'hC2) begin n_fail++; $display("FAIL mask_third_job: got %h expected %h", sched.core_job, 32'hC2); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mask_empty: got %0d expected %0d", fifo_count, 0); end
    endtask

    // Halt with two queued jobs and four busy cores, then recover
    task automatic test_halt();
        do_reset();
        enable    = 1'b1;
        core_mask = 8'h0F;
        for (int i = 0; i < 6; i++) begin
            sched.job_valid = 1'b1;
            sched.job_data  = 32'hD0 + 32'(i);
            step();
        end
        sched.job_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL halt_pre_count: got %0d expected %0d", fifo_count, 2); end
        n_tests++; if (sched.core_busy !== 8'h0F) begin n_fail++; $display("FAIL halt_pre_busy: got %h expected %h", sched.core_busy, 8'h0F); end
        emergency_halt  = 1'b1;
        sched.job_valid = 1'b1;
        sched.job_data  = 32'hEE;
        step();
        emergency_halt  = 1'b0;
        sched.job_valid = 1'b0;
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b expected %b", halted, 1'b1); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL halt_flush: got %0d expected %0d", fifo_count, 0); end
        n_tests++; if (sched.core_busy !== 8'h00) begin n_fail++; $display("FAIL halt_busy: got %h expected %h", sched.core_busy, 8'h00); end
        n_tests++; if (sched.job_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready: got %b expected %b", sched.job_ready, 1'b0); end
        n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL halt_start: got %h expected %h", sched.core_start, 8'h00); end
        repeat (2) step();
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold_enabled: got %b expected %b", halted, 1'b1); end
        enable = 1'b0;
        step();
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_exit: got %b expected %b", halted, 1'b0); end
        n_tests++; if (sched.job_ready !== 1'b1) begin n_fail++; $display("FAIL halt_exit_ready: got %b expected %b", sched.job_ready, 1'b1); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL halt_exit_count: got %0d expected %0d", fifo_count, 0); end
    endtask

    // Core 0 started and never completes
    task automatic test_watchdog();
        do_reset();
        enable          = 1'b1;
        core_mask       = 8'h01;
        sched.job_valid = 1'b1;
        sched.job_data  = 32'hF0;
        step();
        sched.job_valid = 1'b0;
        step();
        n_tests++; if (sched.core_start !== 8'h01) begin n_fail++; $display("FAIL wdog_start: got %h expected %h", sched.core_start, 8'h01); end
`ifdef S247_SCHED_WDOG_EN
        repeat (15) step();
        n_tests++; if (sched.core_busy !== 8'h01) begin n_fail++; $display("FAIL wdog_busy_early: got %h expected %h", sched.core_busy, 8'h01); end
        n_tests++; if (timeout !== 8'h00) begin n_fail++; $display("FAIL wdog_early: got %h expected %h", timeout, 8'h00); end
        step();
        n_tests++; if (timeout !== 8'h01) begin n_fail++; $display("FAIL wdog_fire: got %h expected %h", timeout, 8'h01); end
        n_tests++; if (sched.core_busy !== 8'h00) begin n_fail++; $display("FAIL wdog_busy_clr: got %h expected %h", sched.core_busy, 8'h00); end
        repeat (3) step();
        n_tests++; if (timeout !== 8'h01) begin n_fail++; $display("FAIL wdog_sticky: got %h expected %h", timeout, 8'h01); end
`else
        repeat (20) step();
        n_tests++; if (timeout !== 8'h00) begin n_fail++; $display("FAIL wdog_off_timeout: got %h expected %h", timeout, 8'h00); end
        n_tests++; if (sched.core_busy !== 8'h01) begin n_fail++; $display("FAIL wdog_off_busy: got %h expected %h", sched.core_busy, 8'h01); end
`endif
        sched.core_done = 8'h01;
        step();
        sched.core_done = 8'h00;
    endtask

    // Reset landing on a dispatch cycle, and reset cutting a live start pulse
    task automatic test_reset_dispatch();
        do_reset();
        core_mask       = 8'hFF;
        sched.job_valid = 1'b1;
        sched.job_data  = 32'h6A;
        step();
        sched.job_valid = 1'b0;
        enable = 1'b1;
        rst_n  = 1'b0;
        #1;
        n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL rd_start_async: got %h expected %h", sched.core_start, 8'h00); end
        step();
        n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL rd_start_edge: got %h expected %h", sched.core_start, 8'h00); end
        n_tests++; if (sched.core_job !== 32'h0) begin n_fail++; $display("FAIL rd_job: got %h expected %h", sched.core_job, 32'h0); end
        n_tests++; if (sched.core_busy !== 8'h00) begin n_fail++; $display("FAIL rd_busy: got %h expected %h", sched.core_busy, 8'h00); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rd_count: got %0d expected %0d", fifo_count, 0); end
        n_tests++; if (halted !== 1'b0 || timeout !== 8'h00) begin n_fail++; $display("FAIL rd_flags: got halted=%b timeout=%h expected halted=0 timeout=00", halted, timeout); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL rd_no_escape[%0d]: got %h expected %h", i, sched.core_start, 8'h00); end
        end
        sched.job_valid = 1'b1;
        sched.job_data  = 32'h7B;
        step();
        sched.job_valid = 1'b0;
        step();
        n_tests++; if (sched.core_start !== 8'h01) begin n_fail++; $display("FAIL rd_live_start: got %h expected %h", sched.core_start, 8'h01); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (sched.core_start !== 8'h00) begin n_fail++; $display("FAIL rd_cut_start: got %h expected %h", sched.core_start, 8'h00); end
        n_tests++; if (sched.core_job !== 32'h0) begin n_fail++; $display("FAIL rd_cut_job: got %h expected %h", sched.core_job, 32'h0); end
        n_tests++; if (sched.core_busy !== 8'h00) begin n_fail++; $display("FAIL rd_cut_busy: got %h expected %h", sched.core_busy, 8'h00); end
        step();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive_idle();
        test_reset();
        test_round_robin();
        test_fifo_full();
        test_mask();
        test_halt();
        test_watchdog();
        test_reset_dispatch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_s247_core_scheduler
`default_nettype wire
